// File: rtl/fight_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fight_pkg : phase encoding, skill tables and skill code constants
// Revision  : 1.0
// ------------------------------------------------------------------
package fight_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [2:0] skill_t;

  localparam phase_t PH_IDLE    = 3'd0;
  localparam phase_t PH_WINDUP  = 3'd1;
  localparam phase_t PH_ACTIVE  = 3'd2;
  localparam phase_t PH_RECOVER = 3'd3;
  localparam phase_t PH_KO      = 3'd4;

  localparam skill_t SK_TELEPORT = 3'd0;
  localparam skill_t SK_HEAVY    = 3'd7;

  function automatic logic [7:0] dmg_of(input skill_t code);
    logic [7:0] d;
    case (code)
      3'd0:    d = 8'd0;
      3'd1:    d = 8'd3;
      3'd2:    d = 8'd4;
      3'd3:    d = 8'd5;
      3'd4:    d = 8'd4;
      3'd5:    d = 8'd6;
      3'd6:    d = 8'd7;
      default: d = 8'd12;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] cost_of(input skill_t code);
    logic [3:0] c;
    case (code)
      3'd0:    c = 4'd2;
      3'd1:    c = 4'd1;
      3'd2:    c = 4'd1;
      3'd3:    c = 4'd2;
      3'd4:    c = 4'd2;
      3'd5:    c = 4'd3;
      3'd6:    c = 4'd3;
      default: c = 4'd5;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skill_regen_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// skill_regen_timer : free-running regen counter, one tick per PERIOD
// Revision          : 1.0
// ------------------------------------------------------------------
module skill_regen_timer #(
  parameter int PERIOD = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/skill_executor.sv
`default_nettype none
// ------------------------------------------------------------------
// skill_executor : per-player skill FSM, energy/HP datapath, KO detect
// Optional combo chaining enabled by defining SKILL_COMBO_EN.
// Revision       : 1.0
// ------------------------------------------------------------------
module skill_executor
  import fight_pkg::*;
#(
  parameter int HP_INIT      = 100,
  parameter int ENERGY_MAX   = 15,
  parameter int WINDUP_CYC   = 2,
  parameter int ACTIVE_CYC   = 1,
  parameter int RECOVER_CYC  = 3,
  parameter int REGEN_PERIOD = 64
`ifdef SKILL_COMBO_EN
  ,
  parameter int COMBO_WINDOW = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       skill_valid,
  input  logic [2:0] skill,
  output logic       busy,
  output logic [2:0] phase,
  output logic       hit_pulse,
  output logic [7:0] damage_out,
  output logic [7:0] enemy_hp,
  output logic [3:0] energy,
  output logic       drop_pulse,
  output logic       ko
);

  localparam logic [3:0] EMAX   = 4'(ENERGY_MAX);
  localparam logic [7:0] W_LAST = 8'(WINDUP_CYC - 1);
  localparam logic [7:0] A_LAST = 8'(ACTIVE_CYC - 1);
  localparam logic [7:0] R_LAST = 8'(RECOVER_CYC - 1);

  phase_t     state;
  logic [7:0] cnt;
  skill_t     cur_skill;
  logic [1:0] combo;
  logic       tick;
  logic       regen_en;
  logic       accept;
  logic       start_hit;
  skill_t     hit_code;
  logic [3:0] cost;
  logic [7:0] base_dmg;
  logic [7:0] damage;
  logic [7:0] hp_after;
  logic [4:0] spend_sum;
  logic [3:0] energy_spent;
  logic [3:0] energy_regen;

  assign regen_en = (state != PH_KO);

  skill_regen_timer #(
    .PERIOD (REGEN_PERIOD)
  ) u_regen (
    .clk    (clk),
    .reset  (reset),
    .enable (regen_en),
    .tick   (tick)
  );

  assign cost   = cost_of(skill);
  assign accept = (state == PH_IDLE) && skill_valid && (energy >= cost);

  // Teleport lands on the accept edge itself; everything else lands at the end of WINDUP.
  assign start_hit = (accept && (skill == SK_TELEPORT)) ||
                     ((state == PH_WINDUP) && (cnt == 8'd0));
  assign hit_code  = (state == PH_IDLE) ? skill : cur_skill;
  assign base_dmg  = dmg_of(hit_code);
  assign damage    = base_dmg + ((base_dmg != 8'd0) ? {6'd0, combo} : 8'd0);
  assign hp_after  = (enemy_hp > damage) ? (enemy_hp - damage) : 8'd0;

  // Affordability is judged on pre-regen energy; a coincident tick is credited after the spend.
  assign spend_sum    = {1'b0, energy} - {1'b0, cost} + {4'd0, tick};
  assign energy_spent = (spend_sum > {1'b0, EMAX}) ? EMAX : spend_sum[3:0];
  assign energy_regen = (tick && (energy != EMAX)) ? (energy + 4'd1) : energy;

  assign phase = state;
  assign busy  = (state == PH_WINDUP) || (state == PH_ACTIVE) || (state == PH_RECOVER);
  assign ko    = (state == PH_KO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PH_IDLE;
      cnt        <= 8'd0;
      cur_skill  <= SK_TELEPORT;
      enemy_hp   <= 8'(HP_INIT);
      energy     <= EMAX;
      damage_out <= 8'd0;
      hit_pulse  <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      hit_pulse  <= start_hit;
      drop_pulse <= skill_valid && !accept;
      energy     <= accept ? energy_spent : energy_regen;
      if (start_hit) begin
        damage_out <= damage;
        enemy_hp   <= hp_after;
      end
      case (state)
        PH_IDLE: begin
          if (accept) begin
            cur_skill <= skill;
            if (skill == SK_TELEPORT) begin
              state <= PH_ACTIVE;
              cnt   <= A_LAST;
            end else begin
              state <= PH_WINDUP;
              cnt   <= W_LAST;
            end
          end
        end
        PH_WINDUP: begin
          if (cnt == 8'd0) begin
            state <= PH_ACTIVE;
            cnt   <= A_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_ACTIVE: begin
          if (enemy_hp == 8'd0) begin
            state <= PH_KO;
          end else if (cnt == 8'd0) begin
            state <= PH_RECOVER;
            cnt   <= R_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_RECOVER: begin
          if (cnt == 8'd0) begin
            state <= PH_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_KO: begin
          state <= PH_KO;
        end
        default: begin
          state <= PH_IDLE;
        end
      endcase
    end
  end

`ifdef SKILL_COMBO_EN
  logic [4:0] idle_cnt;

  // Reset value is saturated so the first skill after reset never chains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= 5'd31;
      combo    <= 2'd0;
    end else begin
      if ((state == PH_RECOVER) && (cnt == 8'd0)) begin
        idle_cnt <= 5'd0;
      end else if ((state == PH_IDLE) && (idle_cnt != 5'd31)) begin
        idle_cnt <= idle_cnt + 5'd1;
      end
      if (accept) begin
        if (32'(idle_cnt) < COMBO_WINDOW) begin
          combo <= (combo == 2'd3) ? 2'd3 : (combo + 2'd1);
        end else begin
          combo <= 2'd0;
        end
      end
    end
  end
`else
  assign combo = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_skill_executor.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_skill_executor : directed stimulus, timeline model, per-cycle compare
// Revision          : 1.0
// ------------------------------------------------------------------
module tb_skill_executor;
  import fight_pkg::*;

  localparam int HP0 = 100;
  localparam int EMX = 15;
  localparam int W   = 2;
  localparam int A   = 1;
  localparam int R   = 3;
  localparam int P   = 64;
`ifdef SKILL_COMBO_EN
  localparam int WIN = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       skill_valid = 1'b0;
  logic [2:0] skill = 3'd0;
  logic       busy, hit_pulse, drop_pulse, ko;
  logic [2:0] phase;
  logic [7:0] damage_out, enemy_hp;
  logic [3:0] energy;

  int n_checks = 0;
  int n_fail   = 0;

  skill_executor #(
    .HP_INIT      (HP0),
    .ENERGY_MAX   (EMX),
    .WINDUP_CYC   (W),
    .ACTIVE_CYC   (A),
    .RECOVER_CYC  (R),
    .REGEN_PERIOD (P)
`ifdef SKILL_COMBO_EN
    ,
    .COMBO_WINDOW (WIN)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .skill_valid (skill_valid),
    .skill       (skill),
    .busy        (busy),
    .phase       (phase),
    .hit_pulse   (hit_pulse),
    .damage_out  (damage_out),
    .enemy_hp    (enemy_hp),
    .energy      (energy),
    .drop_pulse  (drop_pulse),
    .ko          (ko)
  );

  always #5 clk = ~clk;

  int dmg_t  [8] = '{0, 3, 4, 5, 4, 6, 7, 12};
  int cost_t [8] = '{2, 1, 1, 2, 2, 3, 3, 5};

  // Model: each accepted skill is a timeline of edge marks (hit, end of ACTIVE, end of RECOVER).
  int e, m_energy, m_hp, m_dmg, m_phase, m_combo, m_rn, m_code;
  int t_hit, t_ae, t_re, ko_edge;
  bit m_hit, m_drop, m_act, m_has_re;

  task automatic model_init();
    e = 0; m_energy = EMX; m_hp = HP0; m_dmg = 0; m_phase = 0; m_combo = 0;
    m_rn = 0; m_code = 0; t_hit = 0; t_ae = 0; t_re = 0; ko_edge = -1;
    m_hit = 0; m_drop = 0; m_act = 0; m_has_re = 0;
  endtask

  task automatic model_step();
    bit tick;
    int bonus;
`ifdef SKILL_COMBO_EN
    int gap;
`endif
    e = e + 1;
    tick = (m_phase != 4) && ((m_rn % P) == P - 1);
    if (m_phase != 4) m_rn = m_rn + 1;
    m_hit = 0;
    m_drop = 0;
    if (skill_valid && m_phase == 0 && m_energy >= cost_t[skill]) begin
`ifdef SKILL_COMBO_EN
      gap = m_has_re ? (e - t_re - 1) : 31;
      if (gap > 31) gap = 31;
      m_combo = (gap < WIN) ? ((m_combo < 3) ? m_combo + 1 : 3) : 0;
`else
      m_combo = 0;
`endif
      m_code = int'(skill);
      m_act = 1;
      t_hit = e + ((skill == 3'd0) ? 0 : W);
      t_ae = t_hit + A;
      t_re = t_ae + R;
      m_energy = m_energy - cost_t[skill] + int'(tick);
    end else begin
      if (skill_valid) m_drop = 1;
      m_energy = m_energy + int'(tick);
    end
    if (m_energy > EMX) m_energy = EMX;
    if (m_act && e == t_hit) begin
      bonus = (dmg_t[m_code] > 0) ? m_combo : 0;
      m_hit = 1;
      m_dmg = dmg_t[m_code] + bonus;
      m_hp = (m_hp > m_dmg) ? m_hp - m_dmg : 0;
      if (m_hp == 0) ko_edge = e + 1;
    end
    if (ko_edge >= 0 && e >= ko_edge) m_phase = 4;
    else if (!m_act) m_phase = 0;
    else if (e < t_hit) m_phase = 1;
    else if (e < t_ae) m_phase = 2;
    else if (e < t_re) m_phase = 3;
    else begin
      m_phase = 0;
      m_act = 0;
      m_has_re = 1;
    end
  endtask

  initial begin
    model_init();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_init();
      else model_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("phase", int'(phase), m_phase);
      chk("busy", int'(busy), int'(m_phase >= 1 && m_phase <= 3));
      chk("hit_pulse", int'(hit_pulse), int'(m_hit));
      chk("damage_out", int'(damage_out), m_dmg);
      chk("enemy_hp", int'(enemy_hp), m_hp);
      chk("energy", int'(energy), m_energy);
      chk("drop_pulse", int'(drop_pulse), int'(m_drop));
      chk("ko", int'(ko), int'(m_phase == 4));
    end
  end

  task automatic fire(input int code);
    @(negedge clk);
    skill_valid = 1'b1;
    skill = 3'(code);
    @(negedge clk);
    skill_valid = 1'b0;
    skill = 3'bx;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (phase != 3'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", int'(phase == 3'd0), 1);
  endtask

  task automatic wait_energy(input int need);
    int k = 0;
    while (int'(energy) < need && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("energy_reached", int'(int'(energy) >= need), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int ko_energy;
  int plan [8] = '{7, 7, 7, 7, 7, 7, 7, 5};

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_hp", int'(enemy_hp), 100);
    chk("rst_energy", int'(energy), 15);
    chk("rst_damage", int'(damage_out), 0);
    chk("rst_ko", int'(ko), 0);

    // Skill 3: two WINDUP cycles then a 5-point hit
    fire(3);
    chk("s3_energy", int'(energy), 13);
    chk("s3_windup", int'(phase), 1);
    repeat (2) @(negedge clk);
    chk("s3_hit", int'(hit_pulse), 1);
    chk("s3_damage", int'(damage_out), 5);
    chk("s3_hp", int'(enemy_hp), 95);
    wait_idle();

    // Teleport goes straight to ACTIVE with no damage
    fire(SK_TELEPORT);
    chk("s0_active", int'(phase), 2);
    chk("s0_hit", int'(hit_pulse), 1);
    chk("s0_damage", int'(damage_out), 0);
    chk("s0_hp", int'(enemy_hp), 95);
    chk("s0_energy", int'(energy), 11);
    wait_idle();

    // Insufficient energy: 15 - 5 - 5 - 1 = 4, then heavy is refused
    do_reset();
    fire(7); wait_idle();
    fire(7); wait_idle();
    fire(1); wait_idle();
    fire(SK_HEAVY);
    chk("poor_drop", int'(drop_pulse), 1);
    chk("poor_phase", int'(phase), 0);
    chk("poor_energy", int'(energy), 4);

    // Strobe during RECOVER is dropped; then accept on a regen tick edge
    do_reset();
    fire(7);
    repeat (3) @(negedge clk);
    chk("rec_phase", int'(phase), 3);
    skill_valid = 1'b1;
    skill = 3'd2;
    @(negedge clk);
    skill_valid = 1'b0;
    skill = 3'bx;
    chk("rec_drop", int'(drop_pulse), 1);
    chk("rec_phase2", int'(phase), 3);
    wait_idle();
    fire(7); wait_idle();
    chk("pre_tick_energy", int'(energy), 5);
    begin
      int k = 0;
      while ((m_rn % P) != P - 1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("tick_aligned", int'((m_rn % P) == P - 1), 1);
    end
    skill_valid = 1'b1;
    skill = 3'd5;
    @(negedge clk);
    skill_valid = 1'b0;
    skill = 3'bx;
    chk("tick_energy", int'(energy), 3);
    chk("tick_phase", int'(phase), 1);
    wait_idle();

    // Combo chaining: three quick skill-1 hits, then one after a long gap
    do_reset();
    fire(1); repeat (2) @(negedge clk);
    chk("combo_d1", int'(damage_out), 3);
    wait_idle();
    fire(1); repeat (2) @(negedge clk);
`ifdef SKILL_COMBO_EN
    chk("combo_d2", int'(damage_out), 4);
`else
    chk("combo_d2", int'(damage_out), 3);
`endif
    wait_idle();
    fire(1); repeat (2) @(negedge clk);
`ifdef SKILL_COMBO_EN
    chk("combo_d3", int'(damage_out), 5);
`else
    chk("combo_d3", int'(damage_out), 3);
`endif
    wait_idle();
    repeat (20) @(negedge clk);
    fire(1); repeat (2) @(negedge clk);
    chk("combo_d4", int'(damage_out), 3);
    wait_idle();

    // Whittle HP down to 10 (7 x 12 + 6), then a heavy hit saturates at 0
    do_reset();
    foreach (plan[i]) begin
      wait_energy(cost_t[plan[i]]);
      repeat (12) @(negedge clk);
      fire(plan[i]);
      wait_idle();
    end
    chk("ko_pre_hp", int'(enemy_hp), 10);
    wait_energy(5);
    repeat (12) @(negedge clk);
    fire(SK_HEAVY);
    repeat (2) @(negedge clk);
    chk("ko_hp0", int'(enemy_hp), 0);
    chk("ko_dmg", int'(damage_out), 12);
    @(negedge clk);
    chk("ko_phase", int'(phase), 4);
    chk("ko_flag", int'(ko), 1);
    chk("ko_busy", int'(busy), 0);
    ko_energy = m_energy;
    fire(1);
    chk("ko_drop", int'(drop_pulse), 1);
    chk("ko_stay", int'(phase), 4);
    repeat (130) @(negedge clk);
    chk("ko_energy_frozen", int'(energy), ko_energy);

    // Asynchronous reset in the middle of a WINDUP
    do_reset();
    fire(3);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_phase", int'(phase), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_energy", int'(energy), 15);
    chk("abort_hp", int'(enemy_hp), 100);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
